// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start-edge detection, 2-of-3 bit voting on sample_clk pulses,
// LSB-first shifting, parity/stop checking and a valid/ready output register with overrun flag.
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 sample_clk,
    output logic                 rx_start,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 vld_meta;
    logic                 vld_sync;
    logic                 armed;
    logic [3:0]           smp_cnt;
    logic [2:0]           bit_cnt;
    logic [1:0]           votes;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err_q;

    logic start_edge;
    logic voted;
    logic decide;
    logic advance;
    logic last_bit;
    logic go_start;
    logic false_start;
    logic frame_end;
    logic shift_en;
    logic par_chk;

    // vld_* marks when the synchronizer holds real line samples, so a line that is
    // low out of reset cannot arm the detector through the reset value of rx_sync.
    assign start_edge = armed & rx_prev & ~rx_sync;
    assign voted      = (votes[0] & votes[1]) | (votes[0] & rx_sync) | (votes[1] & rx_sync);
    assign decide     = sample_clk && (smp_cnt == 4'd5);
    assign advance    = sample_clk && (smp_cnt == 4'd8);
    assign last_bit   = (bit_cnt == 3'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        go_start    = 1'b0;
        false_start = 1'b0;
        frame_end   = 1'b0;
        shift_en    = 1'b0;
        par_chk     = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    go_start   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (decide && voted) begin
                    false_start = 1'b1;
                    state_next  = IDLE;
                end else if (advance) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                shift_en = decide;
                if (advance && last_bit) state_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                par_chk = decide;
                if (advance) state_next = STOP;
            end
            STOP: begin
                // The stop bit is judged mid-bit so the next start edge is never missed.
                if (decide) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            vld_meta  <= 1'b0;
            vld_sync  <= 1'b0;
            armed     <= 1'b0;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            votes     <= '0;
            shift     <= '0;
            par_err_q <= 1'b0;
            rx_start  <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            vld_meta <= 1'b1;
            vld_sync <= vld_meta;
            rx_start <= go_start;
            rx_done  <= false_start | frame_end;

            if (frame_end && !voted)      armed <= 1'b0;
            else if (vld_sync && rx_sync) armed <= 1'b1;

            if (state == IDLE || state_next == IDLE) begin
                smp_cnt <= '0;
                bit_cnt <= '0;
            end else if (sample_clk) begin
                smp_cnt <= (smp_cnt == 4'd8) ? 4'd0 : smp_cnt + 4'd1;
                if (state == DATA && advance) bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
            end

            if (sample_clk && smp_cnt == 4'd3) votes[0] <= rx_sync;
            if (sample_clk && smp_cnt == 4'd4) votes[1] <= rx_sync;

            if (shift_en) shift <= {voted, shift[DATA_BITS-1:1]};

            if (go_start)     par_err_q <= 1'b0;
            else if (par_chk) par_err_q <= (^shift) ^ voted ^ (PARITY == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_end) begin
            rx_data    <= shift;
            parity_err <= (PARITY != 0) & par_err_q;
            frame_err  <= ~voted;
            rx_valid   <= 1'b1;
            overrun    <= rx_valid & ~rx_ready;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance (A) and an 8E1 instance (B), each with its
// own sample-clock generator and serial line, checked by immediate assertions.
module tb_uart_rx_ctrl;

    localparam int DIV = 4;
    localparam int BIT = 9 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       rdy_a = 1'b1;
    logic       rdy_b = 1'b1;
    logic       sclk_a, sclk_b;
    logic       a_start, a_done, a_valid, a_perr, a_ferr, a_ovr;
    logic       b_start, b_done, b_valid, b_perr, b_ferr, b_ovr;
    logic [7:0] a_data, b_data;

    int n_checks = 0;
    int n_fail = 0;
    int a_starts = 0, a_dones = 0, a_vcyc = 0, a_ovrs = 0, a_both = 0;
    int b_starts = 0, b_dones = 0, b_both = 0;
    logic [7:0] a_cap_data = '0, b_cap_data = '0;
    logic       a_cap_perr = 1'b0, a_cap_ferr = 1'b0, b_cap_perr = 1'b0, b_cap_ferr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .sample_clk(sclk_a),
        .rx_start(a_start), .rx_done(a_done), .rx_data(a_data), .rx_valid(a_valid),
        .rx_ready(rdy_a), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .sample_clk(sclk_b),
        .rx_start(b_start), .rx_done(b_done), .rx_data(b_data), .rx_valid(b_valid),
        .rx_ready(rdy_b), .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr)
    );

    // Sample-clock generators: run from rx_start until rx_done, one pulse every DIV clocks.
    logic       en_a, en_b;
    logic [7:0] div_a, div_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_a <= 1'b0; div_a <= '0; sclk_a <= 1'b0;
        end else begin
            sclk_a <= 1'b0;
            if (a_start) begin
                en_a <= 1'b1; div_a <= '0;
            end else if (a_done) begin
                en_a <= 1'b0;
            end else if (en_a) begin
                if (div_a == 8'(DIV - 1)) begin
                    div_a <= '0; sclk_a <= 1'b1;
                end else div_a <= div_a + 8'd1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_b <= 1'b0; div_b <= '0; sclk_b <= 1'b0;
        end else begin
            sclk_b <= 1'b0;
            if (b_start) begin
                en_b <= 1'b1; div_b <= '0;
            end else if (b_done) begin
                en_b <= 1'b0;
            end else if (en_b) begin
                if (div_b == 8'(DIV - 1)) begin
                    div_b <= '0; sclk_b <= 1'b1;
                end else div_b <= div_b + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_start) a_starts <= a_starts + 1;
        if (a_done)  a_dones  <= a_dones + 1;
        if (a_valid) a_vcyc   <= a_vcyc + 1;
        if (a_ovr)   a_ovrs   <= a_ovrs + 1;
        if (a_start && a_done) a_both <= a_both + 1;
        if (a_done && a_valid) begin
            a_cap_data <= a_data; a_cap_perr <= a_perr; a_cap_ferr <= a_ferr;
        end
        if (b_start) b_starts <= b_starts + 1;
        if (b_done)  b_dones  <= b_dones + 1;
        if (b_start && b_done) b_both <= b_both + 1;
        if (b_done && b_valid) begin
            b_cap_data <= b_data; b_cap_perr <= b_perr; b_cap_ferr <= b_ferr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_line(input bit sel, input logic lvl, input int ncyc);
        @(negedge clk);
        if (sel) rx_b = lvl;
        else     rx_a = lvl;
        repeat (ncyc - 1) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit par_en,
                                 input logic par_bit, input logic stop_bit,
                                 input logic after_lvl, input int after_bits);
        drive_line(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_line(sel, data[i], BIT);
        if (par_en) drive_line(sel, par_bit, BIT);
        drive_line(sel, stop_bit, BIT);
        drive_line(sel, after_lvl, after_bits * BIT);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int         s_start, s_done, s_vcyc, s_ovr;
    logic [7:0] part;

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_a_data", a_data, 8'h00);
        checkOutput("reset_a_flags", {a_start, a_done, a_valid, a_perr, a_ferr, a_ovr}, 6'b0);
        checkOutput("reset_b_flags", {b_start, b_done, b_valid, b_perr, b_ferr, b_ovr}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0xA5 with ready held high
        s_start = a_starts; s_done = a_dones; s_vcyc = a_vcyc; s_ovr = a_ovrs;
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        settle();
        checkOutput("a5_starts", a_starts - s_start, 1);
        checkOutput("a5_dones", a_dones - s_done, 1);
        checkOutput("a5_valid_cycles", a_vcyc - s_vcyc, 1);
        checkOutput("a5_data", a_cap_data, 8'hA5);
        checkOutput("a5_errs", {a_cap_perr, a_cap_ferr}, 2'b00);
        checkOutput("a5_overrun", a_ovrs - s_ovr, 0);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        settle();
        checkOutput("par1_data", b_cap_data, 8'h03);
        checkOutput("par1_perr", b_cap_perr, 1'b1);
        checkOutput("par1_ferr", b_cap_ferr, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        settle();
        checkOutput("par0_data", b_cap_data, 8'h03);
        checkOutput("par0_perr", b_cap_perr, 1'b0);
        checkOutput("par_b_dones", b_dones, 2);

        // Break: stop bit low, line held low for three more frames
        s_start = a_starts; s_done = a_dones; s_vcyc = a_vcyc;
        applyStimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 30);
        settle();
        checkOutput("brk_starts", a_starts - s_start, 1);
        checkOutput("brk_valid_cycles", a_vcyc - s_vcyc, 1);
        checkOutput("brk_data", a_cap_data, 8'h81);
        checkOutput("brk_ferr", a_cap_ferr, 1'b1);
        drive_line(1'b0, 1'b1, 3 * BIT);
        settle();
        checkOutput("brk_high_no_start", a_starts - s_start, 1);
        applyStimulus(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        settle();
        checkOutput("brk_resume_starts", a_starts - s_start, 2);
        checkOutput("brk_resume_data", a_cap_data, 8'hC3);
        checkOutput("brk_resume_ferr", a_cap_ferr, 1'b0);

        // Two-sample-period glitch on the idle line
        s_start = a_starts; s_done = a_dones; s_vcyc = a_vcyc;
        drive_line(1'b0, 1'b0, 2 * DIV);
        drive_line(1'b0, 1'b1, 4 * BIT);
        settle();
        checkOutput("glitch_starts", a_starts - s_start, 1);
        checkOutput("glitch_dones", a_dones - s_done, 1);
        checkOutput("glitch_valid_cycles", a_vcyc - s_vcyc, 0);

        // Back-to-back bytes with the consumer stalled
        @(negedge clk);
        rdy_a = 1'b0;
        s_ovr = a_ovrs;
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        settle();
        checkOutput("ovr_first_valid", a_valid, 1'b1);
        checkOutput("ovr_first_data", a_data, 8'h11);
        checkOutput("ovr_first_pulses", a_ovrs - s_ovr, 0);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        settle();
        checkOutput("ovr_pulses", a_ovrs - s_ovr, 1);
        checkOutput("ovr_data", a_data, 8'h22);
        @(negedge clk);
        checkOutput("ovr_hold_valid", a_valid, 1'b1);
        rdy_a = 1'b1;
        settle();
        checkOutput("ovr_drain_valid", a_valid, 1'b0);

        // Reset in the middle of data bit 4 of 0x5A, with an older byte still pending
        @(negedge clk);
        rdy_a = 1'b0;
        applyStimulus(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        settle();
        checkOutput("rst_pending_valid", a_valid, 1'b1);
        s_done = a_dones;
        part = 8'h5A;
        drive_line(1'b0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_line(1'b0, part[i], BIT);
        drive_line(1'b0, part[4], BIT / 2);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #1;
        checkOutput("rst_data", a_data, 8'h00);
        checkOutput("rst_flags", {a_start, a_done, a_valid, a_perr, a_ferr, a_ovr}, 6'b0);
        repeat (5) @(negedge clk);
        checkOutput("rst_no_done", a_dones - s_done, 0);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        repeat (10) @(negedge clk);
        s_vcyc = a_vcyc; s_ovr = a_ovrs;
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        settle();
        checkOutput("post_rst_data", a_cap_data, 8'h3C);
        checkOutput("post_rst_errs", {a_cap_perr, a_cap_ferr}, 2'b00);
        checkOutput("post_rst_valid_cycles", a_vcyc - s_vcyc, 1);
        checkOutput("post_rst_overrun", a_ovrs - s_ovr, 0);

        checkOutput("a_start_done_overlap", a_both, 0);
        checkOutput("b_start_done_overlap", b_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
